dual_queue_ctrl: RTL and testbench

Controller that partitions one single-write-port, asynchronous-read memory (2**addr_size words) into two independent queues of 2**(addr_size-1) words each. Two write requesters share the memory's single write port through a round-robin arbiter. One read port pops from a selectable queue. The block drives the memory's write enable, write address, write data and read address, and returns the memory's read data to the consumer. It owns all pointers, occupancy counts and full/empty flags; the memory array is instantiated alongside it.

---
 rtl/dual_queue_ctrl.sv | 123 ++++++++++++
 tb/tb_dual_queue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dual_queue_ctrl: two FIFOs sharing one 1W / async-read memory        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dual_queue_ctrl #(
  parameter int ADDR_SIZE  = 4,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_data0,
  input  logic [WORD_WIDTH-1:0] wr_data1,
  output logic [1:0]            wr_ready,
  input  logic                  rd_en,
  input  logic                  rd_ch,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            full,
  output logic [1:0]            empty,
  output logic [ADDR_SIZE-1:0]  count0,
  output logic [ADDR_SIZE-1:0]  count1,
  output logic                  mem_we,
  output logic [ADDR_SIZE-1:0]  mem_addr_w,
  output logic [WORD_WIDTH-1:0] mem_data_w,
  output logic [ADDR_SIZE-1:0]  mem_addr_r,
  input  logic [WORD_WIDTH-1:0] mem_data_r
);

  localparam int PW = ADDR_SIZE - 1;
  localparam logic [ADDR_SIZE-1:0] C_HALF = {1'b1, {PW{1'b0}}};

  logic [2*PW-1:0]        w_wptr;
  logic [2*PW-1:0]        w_rptr;
  logic [2*ADDR_SIZE-1:0] w_count;
  logic [1:0]             w_elig;
  logic [1:0]             w_grant;
  logic [1:0]             w_pop;
  logic                   w_gsel;
  logic                   prio_q;
  logic                   prio_d;

  for (genvar i = 0; i < 2; i++) begin : g_queue
    logic [PW-1:0]        wptr_q;
    logic [PW-1:0]        wptr_d;
    logic [PW-1:0]        rptr_q;
    logic [PW-1:0]        rptr_d;
    logic [ADDR_SIZE-1:0] count_q;
    logic [ADDR_SIZE-1:0] count_d;

    // Pointers wrap naturally at the half depth; a same-cycle push and pop leave the count alone.
    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (w_grant[i]) wptr_d = wptr_q + PW'(1);
      if (w_pop[i])   rptr_d = rptr_q + PW'(1);
      case ({w_grant[i], w_pop[i]})
        2'b10:   count_d = count_q + ADDR_SIZE'(1);
        2'b01:   count_d = count_q - ADDR_SIZE'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
      end
    end

    assign full[i]  = (count_q == C_HALF);
    assign empty[i] = (count_q == '0);
    assign w_pop[i] = rd_en & (rd_ch == 1'(i)) & ~empty[i];

    assign w_wptr[i*PW +: PW]                 = wptr_q;
    assign w_rptr[i*PW +: PW]                 = rptr_q;
    assign w_count[i*ADDR_SIZE +: ADDR_SIZE]  = count_q;
  end

  // Full queues are never eligible, so a write into a full queue being popped simply loses the cycle.
  always_comb begin
    w_elig  = wr_valid & ~full;
    w_grant = 2'b00;
    if (!rst) begin
      case (w_elig)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = prio_q ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (|w_grant) prio_d = ~w_grant[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign w_gsel     = w_grant[1];
  assign wr_ready   = w_grant;
  assign mem_we     = |w_grant;
  assign mem_addr_w = {w_gsel, w_gsel ? w_wptr[2*PW-1:PW] : w_wptr[PW-1:0]};
  assign mem_data_w = w_gsel ? wr_data1 : wr_data0;
  assign mem_addr_r = {rd_ch, rd_ch ? w_rptr[2*PW-1:PW] : w_rptr[PW-1:0]};
  assign rd_data    = mem_data_r;
  assign rd_valid   = ~empty[rd_ch];
  assign count0     = w_count[ADDR_SIZE-1:0];
  assign count1     = w_count[2*ADDR_SIZE-1:ADDR_SIZE];

endmodule
`default_nettype wire

// File: tb/tb_dual_queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dual_queue_ctrl: directed stimulus against a queue-level model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dual_queue_ctrl;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] wr_valid;
  logic [7:0] wr_data0;
  logic [7:0] wr_data1;
  logic [1:0] wr_ready;
  logic       rd_en;
  logic       rd_ch;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [1:0] full;
  logic [1:0] empty;
  logic [3:0] count0;
  logic [3:0] count1;
  logic       mem_we;
  logic [3:0] mem_addr_w;
  logic [7:0] mem_data_w;
  logic [3:0] mem_addr_r;
  logic [7:0] mem_data_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dual_queue_ctrl #(.ADDR_SIZE(4), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count0(count0), .count1(count1),
    .mem_we(mem_we), .mem_addr_w(mem_addr_w), .mem_data_w(mem_data_w),
    .mem_addr_r(mem_addr_r), .mem_data_r(mem_data_r)
  );

  // Single-write-port memory with asynchronous read, sitting beside the controller.
  logic [7:0] mem [16];
  always @(posedge clk) if (mem_we) mem[mem_addr_w] <= mem_data_w;
  assign mem_data_r = mem[mem_addr_r];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue-level model: contents as SV queues, plus lifetime write/pop counts per queue.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         wcnt[2] = '{0, 0};
  int         rcnt[2] = '{0, 0};
  bit         m_prio  = 1'b0;
  logic [1:0] m_g;
  bit         p0, p1;

  function automatic int sz(input logic c);
    return c ? q1.size() : q0.size();
  endfunction

  function automatic logic [1:0] exp_grant();
    logic [1:0] e;
    if (rst) return 2'b00;
    e[0] = wr_valid[0] && (q0.size() < HALF);
    e[1] = wr_valid[1] && (q1.size() < HALF);
    if (e == 2'b11) return m_prio ? 2'b10 : 2'b01;
    return e;
  endfunction

  // Inputs only change just after posedge, so at negedge they are the values the next edge samples.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      wcnt   = '{0, 0};
      rcnt   = '{0, 0};
      m_prio = 1'b0;
    end
    m_g = exp_grant();
    check("wr_ready", wr_ready, m_g);
    check("mem_we", mem_we, int'(|m_g));
    if (|m_g) begin
      check("mem_addr_w", mem_addr_w, int'(m_g[1]) * HALF + wcnt[m_g[1]] % HALF);
      check("mem_data_w", mem_data_w, m_g[1] ? wr_data1 : wr_data0);
    end
    check("mem_addr_r", mem_addr_r, int'(rd_ch) * HALF + rcnt[rd_ch] % HALF);
    check("rd_valid", rd_valid, int'(sz(rd_ch) != 0));
    if (sz(rd_ch) != 0) check("rd_data", rd_data, rd_ch ? q1[0] : q0[0]);
    check("full", full, {q1.size() == HALF, q0.size() == HALF});
    check("empty", empty, {q1.size() == 0, q0.size() == 0});
    check("count0", count0, q0.size());
    check("count1", count1, q1.size());
    if (!rst) begin
      p0 = rd_en && !rd_ch && (q0.size() > 0);
      p1 = rd_en &&  rd_ch && (q1.size() > 0);
      if (p0) begin void'(q0.pop_front()); rcnt[0]++; end
      if (p1) begin void'(q1.pop_front()); rcnt[1]++; end
      if (m_g[0]) begin q0.push_back(wr_data0); wcnt[0]++; m_prio = 1'b1; end
      if (m_g[1]) begin q1.push_back(wr_data1); wcnt[1]++; m_prio = 1'b0; end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic re, input logic rc);
    @(posedge clk);
    #1;
    wr_valid = v;
    wr_data0 = d0;
    wr_data1 = d1;
    rd_en    = re;
    rd_ch    = rc;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    wr_valid = 2'b00;
    rd_en    = 1'b0;
    rd_ch    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_count0", count0, 0);
    check("arst_count1", count1, 0);
    check("arst_empty", empty, 3);
    check("arst_full", full, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_mem_we", mem_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int exp_addr[6] = '{0, 8, 1, 9, 2, 10};

  initial begin
    rst      = 1'b1;
    wr_valid = 2'b11;
    wr_data0 = 8'h11;
    wr_data1 = 8'h22;
    rd_en    = 1'b1;
    rd_ch    = 1'b1;
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_empty", empty, 3);
    check("rst_full", full, 0);
    check("rst_mem_addr_r", mem_addr_r, 8);
    check("rst_rd_valid", rd_valid, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_valid = 2'b00;
    rd_en    = 1'b0;
    rd_ch    = 1'b0;

    // Fill queue 0, refuse a ninth word, drain in order.
    for (int k = 0; k < 8; k++) begin
      drive(2'b01, 8'(8'h10 + k), 8'h00, 1'b0, 1'b0);
      check("fill_addr", mem_addr_w, k);
    end
    drive(2'b01, 8'h18, 8'h00, 1'b0, 1'b0);
    check("full_ready", wr_ready, 0);
    check("full_we", mem_we, 0);
    check("full_count0", count0, 8);
    check("full_flag", full[0], 1);
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
      check("drain_data", rd_data, 8'h10 + k);
    end
    idle();
    check("drain_empty", empty[0], 1);
    check("drain_count0", count0, 0);

    // Both channels requesting: strict alternation starting from channel 0.
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 8'(8'h20 + k), 8'(8'h30 + k), 1'b0, 1'b0);
      check("rr_addr", mem_addr_w, exp_addr[k]);
      check("rr_grant", wr_ready, (k % 2 == 1) ? 2 : 1);
    end
    idle();
    check("rr_count0", count0, 3);
    check("rr_count1", count1, 3);
    pulse_reset();

    // Queue 1 pointer wrap.
    for (int k = 0; k < 8; k++) drive(2'b10, 8'h00, 8'(8'h30 + k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
      check("q1_data", rd_data, 8'h30 + k);
    end
    drive(2'b10, 8'h00, 8'hA5, 1'b0, 1'b1);
    check("wrap_addr", mem_addr_w, 8);
    drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
    check("wrap_valid", rd_valid, 1);
    check("wrap_data", rd_data, 8'hA5);
    idle();
    check("wrap_empty", empty[1], 1);

    // Same-cycle write and pop on queue 0, partially full then full.
    for (int k = 0; k < 3; k++) drive(2'b01, 8'(8'h40 + k), 8'h00, 1'b0, 1'b0);
    drive(2'b01, 8'h50, 8'h00, 1'b1, 1'b0);
    check("wp_data", rd_data, 8'h40);
    check("wp_ready", wr_ready, 1);
    idle();
    check("wp_count0", count0, 3);
    for (int k = 0; k < 5; k++) drive(2'b01, 8'(8'h51 + k), 8'h00, 1'b0, 1'b0);
    drive(2'b01, 8'h60, 8'h00, 1'b1, 1'b0);
    check("wpf_ready", wr_ready, 0);
    check("wpf_we", mem_we, 0);
    check("wpf_valid", rd_valid, 1);
    idle();
    check("wpf_count0", count0, 7);
    check("wpf_full", full[0], 0);

    // Pop request on an empty queue while it is written: write only.
    for (int k = 0; k < 7; k++) drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    idle();
    check("we_empty", empty[0], 1);
    drive(2'b01, 8'h70, 8'h00, 1'b1, 1'b0);
    check("we_valid", rd_valid, 0);
    check("we_ready", wr_ready, 1);
    idle();
    check("we_count0", count0, 1);
    check("we_data", rd_data, 8'h70);

    // Mixed traffic on both queues, checked by the model alone.
    for (int k = 0; k < 24; k++)
      drive(2'(k % 4), 8'(8'h80 + k), 8'(8'hC0 + k), 1'(k % 3 != 0), 1'((k / 4) % 2));
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
